// File: rtl/beam_row_sequencer.sv
// beam_row_sequencer: drives the beam engine one stored grid row at a time,
// chaining each row's output beam into the next row and summing split counts.
module beam_row_sequencer #(
  parameter int ROW_AW   = 4,
  parameter int WD_LIMIT = 31
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              row_we,
  input  logic [ROW_AW-1:0] row_addr,
  input  logic [15:0]       row_data,
  input  logic [ROW_AW:0]   row_count,
  input  logic [15:0]       seed_beam,
  input  logic              go,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [15:0]       total_splits,
  output logic [15:0]       final_beam,
  output logic [15:0]       eng_grid,
  output logic [15:0]       eng_beam,
  output logic              eng_start,
  input  logic [15:0]       eng_beam_out,
  input  logic              eng_done,
  input  logic [7:0]        eng_split_count
);

  localparam int DEPTH = 1 << ROW_AW;
  localparam int WD_W  = $clog2(WD_LIMIT + 1);

  localparam logic [ROW_AW:0]   IDX_ONE  = 1;
  localparam logic [WD_W-1:0]   WD_ONE   = 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WD_LIMIT - 1);
  localparam logic [ROW_AW-1:0] ROW_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e          state_q;
  logic [15:0]     mem_q [DEPTH];
  logic [ROW_AW:0] cnt_q;
  logic [ROW_AW:0] idx_q;
  logic [WD_W-1:0] wd_q;
  logic [15:0]     beam_q;
  logic [15:0]     total_q;
  logic [15:0]     grid_q;
  logic [15:0]     eng_beam_q;
  logic            busy_q;
  logic            finished_q;
  logic            error_q;
  logic            start_q;

  logic [ROW_AW:0] idx_inc_d;
  logic            last_row_d;
  logic            wd_expire_d;

  // The row counter is one bit wider than the address so row_count values
  // above the depth still terminate; the address simply wraps.
  always_comb begin
    idx_inc_d   = idx_q + IDX_ONE;
    last_row_d  = (idx_inc_d == cnt_q);
    wd_expire_d = (wd_q == WD_LAST);
  end

  // NOTE: row storage is deliberately left out of reset so it maps onto plain
  // RAM; the host always loads rows before starting a run.
  always_ff @(posedge clock) begin
    if (row_we && !busy_q) begin
      mem_q[row_addr] <= row_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wd_q       <= '0;
      beam_q     <= '0;
      total_q    <= '0;
      grid_q     <= '0;
      eng_beam_q <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      finished_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            cnt_q   <= row_count;
            beam_q  <= seed_beam;
            idx_q   <= '0;
            total_q <= '0;
            error_q <= 1'b0;
            if (row_count == '0) begin
              state_q    <= FIN;
              finished_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              busy_q     <= 1'b1;
              start_q    <= 1'b1;
              grid_q     <= mem_q[ROW_ZERO];
              eng_beam_q <= seed_beam;
            end
          end
        end

        ISSUE: begin
          state_q <= WAIT;
          wd_q    <= '0;
        end

        // Engine inputs stay frozen here; they only change when the next row issues.
        WAIT: begin
          if (eng_done) begin
            beam_q  <= eng_beam_out;
            total_q <= total_q + {8'h00, eng_split_count};
            idx_q   <= idx_inc_d;
            if (last_row_d) begin
              state_q    <= FIN;
              busy_q     <= 1'b0;
              finished_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              start_q    <= 1'b1;
              grid_q     <= mem_q[idx_inc_d[ROW_AW-1:0]];
              eng_beam_q <= eng_beam_out;
            end
          end else if (wd_expire_d) begin
            error_q    <= 1'b1;
            state_q    <= FIN;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_ONE;
          end
        end

        FIN: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign finished     = finished_q;
  assign error        = error_q;
  assign total_splits = total_q;
  assign final_beam   = beam_q;
  assign eng_grid     = grid_q;
  assign eng_beam     = eng_beam_q;
  assign eng_start    = start_q;

endmodule

// File: tb/tb_beam_row_sequencer.sv
// tb_beam_row_sequencer: directed runs against a behavioural beam engine, with
// scoreboard queues for engine starts and run completions.
module tb_beam_row_sequencer;

  localparam int ROW_AW   = 4;
  localparam int WD_LIMIT = 31;

  logic              clock = 1'b0;
  logic              clear;
  logic              row_we;
  logic [ROW_AW-1:0] row_addr;
  logic [15:0]       row_data;
  logic [ROW_AW:0]   row_count;
  logic [15:0]       seed_beam;
  logic              go;
  logic              busy;
  logic              finished;
  logic              error;
  logic [15:0]       total_splits;
  logic [15:0]       final_beam;
  logic [15:0]       eng_grid;
  logic [15:0]       eng_beam;
  logic              eng_start;
  logic [15:0]       eng_beam_out;
  logic              eng_done;
  logic [7:0]        eng_split_count;

  always #5 clock = ~clock;

  beam_row_sequencer #(.ROW_AW(ROW_AW), .WD_LIMIT(WD_LIMIT)) dut (
    .clock           (clock),
    .clear           (clear),
    .row_we          (row_we),
    .row_addr        (row_addr),
    .row_data        (row_data),
    .row_count       (row_count),
    .seed_beam       (seed_beam),
    .go              (go),
    .busy            (busy),
    .finished        (finished),
    .error           (error),
    .total_splits    (total_splits),
    .final_beam      (final_beam),
    .eng_grid        (eng_grid),
    .eng_beam        (eng_beam),
    .eng_start       (eng_start),
    .eng_beam_out    (eng_beam_out),
    .eng_done        (eng_done),
    .eng_split_count (eng_split_count)
  );

  int errors = 0;
  int checks = 0;
  int ecnt = 0;
  int go_edge = 0;
  int fin_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural engine: 17 RUN cycles then one DONE cycle; inputs evaluated on the last RUN cycle.
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE} eng_st_e;
  eng_st_e     eng_st;
  int          eng_cnt;
  logic [15:0] eng_res;
  logic [7:0]  eng_sc;
  logic        stub_dead = 1'b0;

  function automatic logic [23:0] eng_eval(input logic [15:0] g, input logic [15:0] b);
    logic [15:0] o;
    logic [7:0]  n;
    o = '0;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        if (g[i]) begin
          n = n + 8'd1;
          if (i > 0)  o[i-1] = 1'b1;
          if (i < 15) o[i+1] = 1'b1;
        end else begin
          o[i] = 1'b1;
        end
      end
    end
    return {n, o};
  endfunction

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      eng_st  <= E_IDLE;
      eng_cnt <= 0;
      eng_res <= '0;
      eng_sc  <= '0;
    end else begin
      case (eng_st)
        E_IDLE: if (eng_start && !stub_dead) begin
          eng_st  <= E_RUN;
          eng_cnt <= 0;
        end
        E_RUN: begin
          if (eng_cnt == 16) begin
            {eng_sc, eng_res} <= eng_eval(eng_grid, eng_beam);
            eng_st <= E_DONE;
          end
          eng_cnt <= eng_cnt + 1;
        end
        default: eng_st <= E_IDLE;
      endcase
    end
  end

  assign eng_done        = (eng_st == E_DONE);
  assign eng_beam_out    = (eng_st == E_DONE) ? eng_res : 16'h0000;
  assign eng_split_count = (eng_st == E_DONE) ? eng_sc : 8'h00;

  always @(posedge clock) ecnt <= ecnt + 1;

  // Scoreboard queues
  typedef struct {
    int          cyc;
    logic [15:0] grid;
    logic [15:0] beam;
  } start_t;

  typedef struct {
    int          cyc;
    logic [15:0] beam;
    logic [15:0] total;
    logic        err;
  } fin_t;

  start_t st_q[$];
  fin_t   fin_q[$];

  always @(negedge clock) begin
    if (!clear && eng_start) begin
      check("start_expected", 32'(st_q.size() > 0), 32'd1);
      if (st_q.size() > 0) begin
        start_t s;
        s = st_q.pop_front();
        check("start_cycle", 32'(ecnt - go_edge + 1), 32'(s.cyc));
        check("start_grid", 32'(eng_grid), 32'(s.grid));
        check("start_beam", 32'(eng_beam), 32'(s.beam));
      end
    end
    if (!clear && finished) begin
      check("fin_expected", 32'(fin_q.size() > 0), 32'd1);
      if (fin_q.size() > 0) begin
        fin_t f;
        f = fin_q.pop_front();
        check("fin_cycle", 32'(ecnt - go_edge + 1), 32'(f.cyc));
        check("fin_beam", 32'(final_beam), 32'(f.beam));
        check("fin_total", 32'(total_splits), 32'(f.total));
        check("fin_error", 32'(error), 32'(f.err));
        check("fin_busy", 32'(busy), 32'd0);
      end
      fin_seen++;
    end
  end

  task automatic push_start(input int c, input logic [15:0] g, input logic [15:0] b);
    start_t s;
    s.cyc = c; s.grid = g; s.beam = b;
    st_q.push_back(s);
  endtask

  task automatic push_fin(input int c, input logic [15:0] b, input logic [15:0] t, input logic e);
    fin_t f;
    f.cyc = c; f.beam = b; f.total = t; f.err = e;
    fin_q.push_back(f);
  endtask

  task automatic write_row(input logic [ROW_AW-1:0] a, input logic [15:0] d);
    @(negedge clock);
    row_we = 1'b1; row_addr = a; row_data = d;
    @(negedge clock);
    row_we = 1'b0;
  endtask

  // Returns at the falling edge inside cycle 1.
  task automatic start_run(input logic [ROW_AW:0] n, input logic [15:0] seed);
    @(negedge clock);
    row_count = n; seed_beam = seed; go = 1'b1;
    go_edge = ecnt + 1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    int n0;
    int k;
    n0 = fin_seen;
    k = 0;
    while (fin_seen == n0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    check("fin_timeout", 32'(fin_seen != n0), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_finished"}, 32'(finished), 32'd0);
    check({tag, "_error"},    32'(error), 32'd0);
    check({tag, "_total"},    32'(total_splits), 32'd0);
    check({tag, "_beam"},     32'(final_beam), 32'd0);
    check({tag, "_grid"},     32'(eng_grid), 32'd0);
    check({tag, "_ebeam"},    32'(eng_beam), 32'd0);
    check({tag, "_start"},    32'(eng_start), 32'd0);
  endtask

  task automatic expect_two_rows();
    push_start(1, 16'h0100, 16'h0100);
    push_start(20, 16'h0280, 16'h0280);
    push_fin(39, 16'h0540, 16'd3, 1'b0);
  endtask

  initial begin
    clear = 1'b1; row_we = 1'b0; row_addr = '0; row_data = '0;
    row_count = '0; seed_beam = '0; go = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    clear = 1'b0;

    write_row(4'd0, 16'h0100);
    write_row(4'd1, 16'h0280);

    // One row
    push_start(1, 16'h0100, 16'h0100);
    push_fin(20, 16'h0280, 16'd1, 1'b0);
    start_run(5'd1, 16'h0100);
    wait_fin(100);

    // Two rows chained back-to-back
    expect_two_rows();
    start_run(5'd2, 16'h0100);
    wait_fin(100);

    // go and row write while busy are both ignored
    expect_two_rows();
    start_run(5'd2, 16'h0100);
    repeat (4) @(negedge clock);
    check("busy_mid_run", 32'(busy), 32'd1);
    go = 1'b1; row_we = 1'b1; row_addr = 4'd1; row_data = 16'hFFFF; row_count = 5'd0;
    @(negedge clock);
    go = 1'b0; row_we = 1'b0;
    wait_fin(100);

    // Asynchronous clear mid-run, then a full rerun
    push_start(1, 16'h0100, 16'h0100);
    start_run(5'd2, 16'h0100);
    repeat (9) @(negedge clock);
    #1 clear = 1'b1;
    #1 check_reset_vals("clear");
    @(negedge clock);
    clear = 1'b0;
    expect_two_rows();
    start_run(5'd2, 16'h0100);
    wait_fin(100);

    // Dead engine: watchdog abort
    stub_dead = 1'b1;
    push_start(1, 16'h0100, 16'h1234);
    push_fin(33, 16'h1234, 16'd0, 1'b1);
    start_run(5'd1, 16'h1234);
    wait_fin(100);
    repeat (3) @(negedge clock);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_error_sticky", 32'(error), 32'd1);
    stub_dead = 1'b0;

    // Zero rows: immediate finish, and the accepted go clears error
    push_fin(1, 16'hA5A5, 16'd0, 1'b0);
    start_run(5'd0, 16'hA5A5);
    wait_fin(20);
    repeat (2) @(negedge clock);

    check("start_q_drained", 32'(st_q.size()), 32'd0);
    check("fin_q_drained", 32'(fin_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
